// File: rtl/ad9361_spi_pkg.sv
// Shared types and defaults for the AD9361 configuration path
// (arbiter, init sequencer and spi engine).
package ad9361_spi_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // k-th round-robin candidate after ptr, wrapping over 1..n-1 (port 0 is
    // never a round-robin candidate).
    function automatic int rr_slot(input int ptr, input int k, input int n);
        return ((ptr + k - 1) % (n - 1)) + 1;
    endfunction

endpackage

// File: rtl/ad9361_rr_pick.sv
// Combinational winner select: port 0 has absolute priority, the remaining
// ports are searched round-robin starting just after rr_ptr.
module ad9361_rr_pick
    import ad9361_spi_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    // Priority port first, then the first valid round-robin slot.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        if (valid[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                if (!any && valid[rr_slot(int'(rr_ptr), k, NUM_REQ)]) begin
                    grant[rr_slot(int'(rr_ptr), k, NUM_REQ)] = 1'b1;
                    idx = IW'(rr_slot(int'(rr_ptr), k, NUM_REQ));
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ad9361_spi_arb.sv
// Arbitrates register accesses from several requesters onto the single
// AD9361 spi engine, one engine transaction per grant.
//
// state | meaning
// IDLE  | waiting for any req_valid; winner and its fields latched on exit
// ISSUE | one-cycle start pulse to the engine, timeout counter loaded
// WAIT  | waiting for the matching engine end pulse or timeout
// DONE  | one-cycle req_done (and req_err) to the winner, rr_ptr update
module ad9361_spi_arb
    import ad9361_spi_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      busy,
    output logic                      eng_wr_req,
    output logic                      eng_rd_req,
    output logic [ADDR_W-1:0]         eng_addr,
    output logic [DATA_W-1:0]         eng_wdata,
    input  logic                      eng_wr_end,
    input  logic                      eng_rd_end,
    input  logic [DATA_W-1:0]         eng_rd_data
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    // Down-counter terminal count lands so that DONE starts exactly TIMEOUT
    // cycles after the start pulse.
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 2);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        rr_ptr_q;
    logic                 rnw_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 err_q;
    logic [CW-1:0]        cnt_q;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 end_hit;

    ad9361_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Only the end pulse matching the latched direction counts.
    assign end_hit = rnw_q ? eng_rd_end : eng_wr_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an end pulse beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (end_hit || cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request fields, timeout counter, result and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= IW'(1);
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q   <= pick_grant;
                        idx_q   <= pick_idx;
                        rnw_q   <= req_rnw[pick_idx];
                        addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q <= req_wdata[pick_idx*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_LOAD;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                WAIT: begin
                    if (end_hit) begin
                        err_q   <= 1'b0;
                        rdata_q <= rnw_q ? eng_rd_data : '0;
                    end else if (cnt_q == '0) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (idx_q != '0) rr_ptr_q <= idx_q;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign eng_wr_req = (state_q == ISSUE) && !rnw_q;
    assign eng_rd_req = (state_q == ISSUE) &&  rnw_q;
    assign eng_addr   = addr_q;
    assign eng_wdata  = wdata_q;
    assign req_done   = (state_q == DONE) ? gnt_q : '0;
    assign req_err    = (state_q == DONE && err_q) ? gnt_q : '0;
    assign req_rdata  = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_ad9361_spi_arb.sv
// Bench for ad9361_spi_arb: scenario tasks plus a scoreboard monitor that
// checks every engine start and every completion against queued expectations.
module tb_ad9361_spi_arb;

    localparam int NR = 3;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_rnw = '0;
    logic [AW-1:0]    ra [NR];
    logic [DW-1:0]    rw [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_done, req_err;
    logic [DW-1:0]    req_rdata;
    logic             busy, eng_wr_req, eng_rd_req;
    logic [AW-1:0]    eng_addr;
    logic [DW-1:0]    eng_wdata;
    logic             eng_wr_end, eng_rd_end;
    logic [DW-1:0]    eng_rd_data = '0;

    logic m_wr_end = 1'b0, m_rd_end = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    assign eng_wr_end = m_wr_end | s_wr;
    assign eng_rd_end = m_rd_end | s_rd;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = ra[i];
            req_wdata[i*DW +: DW] = rw[i];
        end
    end

    ad9361_spi_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata), .busy(busy),
        .eng_wr_req(eng_wr_req), .eng_rd_req(eng_rd_req), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_wr_end(eng_wr_end), .eng_rd_end(eng_rd_end), .eng_rd_data(eng_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            idx;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [NR-1:0] mon_v;

    // Engine model: answers each start pulse after eng_lat cycles; drives junk
    // read data on write ends so ungated rdata would be caught.
    logic          eng_auto = 1'b0;
    int            eng_lat  = 3;
    logic [DW-1:0] eng_rval = '0;
    logic          mdl_rd;
    always begin
        @(negedge clk);
        if (eng_auto && rst_n && (eng_wr_req || eng_rd_req)) begin
            mdl_rd = eng_rd_req;
            repeat (eng_lat) @(negedge clk);
            eng_rd_data = mdl_rd ? eng_rval : 8'hEE;
            m_rd_end = mdl_rd;
            m_wr_end = !mdl_rd;
            @(negedge clk);
            m_rd_end = 1'b0;
            m_wr_end = 1'b0;
            eng_rd_data = '0;
        end
    end

    // Scoreboard monitor: start pulses peek the head, completions pop it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_wr_req || eng_rd_req) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL start_unexpected: wr=%b rd=%b addr=%h, required no start", eng_wr_req, eng_rd_req, eng_addr);
                end else if (eng_rd_req !== exp_q[0].rnw || eng_wr_req !== !exp_q[0].rnw ||
                             eng_addr !== exp_q[0].addr || (!exp_q[0].rnw && eng_wdata !== exp_q[0].wdata)) begin
                    n_fail++;
                    $display("FAIL start_fields: rd=%b addr=%h wdata=%h, required rd=%b addr=%h wdata=%h",
                             eng_rd_req, eng_addr, eng_wdata, exp_q[0].rnw, exp_q[0].addr, exp_q[0].wdata);
                end
            end
            if (req_done != '0) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: req_done=%b, required none", req_done);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_v = NR'(1) << mon_e.idx;
                    if (req_done !== mon_v || req_err !== (mon_e.err ? mon_v : '0) || req_rdata !== mon_e.rdata) begin
                        n_fail++;
                        $display("FAIL done_fields: done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                                 req_done, req_err, req_rdata, mon_v, mon_e.err ? mon_v : '0, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic push(input int idx, input logic rnw, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rd);
        exp_t e;
        e.idx = idx; e.rnw = rnw; e.addr = a; e.wdata = wd; e.err = err; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget && at < 0; c++) begin
            @(negedge clk);
            if (eng_wr_req || eng_rd_req) at = cyc;
        end
    endtask

    task automatic wait_done(input int budget, output logic [NR-1:0] d, output int at);
        d = '0;
        at = -1;
        for (int c = 0; c < budget && at < 0; c++) begin
            @(negedge clk);
            if (req_done != '0) begin
                d = req_done;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, eng_wr_req, eng_rd_req, req_done, req_err, req_rdata, eng_addr, eng_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b wr=%b rd=%b done=%b err=%b rdata=%h addr=%h wdata=%h, required all 0",
                     busy, eng_wr_req, eng_rd_req, req_done, req_err, req_rdata, eng_addr, eng_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int ts, td;
        logic [NR-1:0] d;
        eng_auto = 1'b1; eng_lat = 20;
        ra[1] = 10'h3F5; rw[1] = 8'h5A; req_rnw[1] = 1'b0;
        push(1, 1'b0, 10'h3F5, 8'h5A, 1'b0, 8'h00);
        req_valid[1] = 1'b1;
        @(negedge clk);
        ts = cyc;
        n_tests++;
        if (eng_wr_req !== 1'b1 || eng_rd_req !== 1'b0 || eng_addr !== 10'h3F5 || eng_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL write_start: wr=%b rd=%b addr=%h wdata=%h, required 1 0 3f5 5a", eng_wr_req, eng_rd_req, eng_addr, eng_wdata);
        end
        @(negedge clk);
        n_tests++;
        if (eng_wr_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_pulse_width: wr=%b busy=%b, required 0 1", eng_wr_req, busy);
        end
        wait_done(100, d, td);
        req_valid[1] = 1'b0;
        n_tests++;
        if (d !== 3'b010 || td - ts !== 21) begin
            n_fail++;
            $display("FAIL write_done: done=%b cycles=%0d, required 010 21", d, td - ts);
        end
    endtask

    task automatic test_read();
        int ts, td;
        logic [NR-1:0] d;
        eng_auto = 1'b1; eng_lat = 5; eng_rval = 8'hC3;
        ra[2] = 10'h037; rw[2] = 8'h00; req_rnw[2] = 1'b1;
        push(2, 1'b1, 10'h037, 8'h00, 1'b0, 8'hC3);
        req_valid[2] = 1'b1;
        wait_start(5, ts);
        wait_done(50, d, td);
        n_tests++;
        if (d !== 3'b100 || req_rdata !== 8'hC3 || req_err !== 3'b000 || td - ts !== 6) begin
            n_fail++;
            $display("FAIL read_done: done=%b rdata=%h err=%b cycles=%0d, required 100 c3 000 6", d, req_rdata, req_err, td - ts);
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_rdata !== 8'h00 || req_done !== 3'b000) begin
            n_fail++;
            $display("FAIL read_rdata_cleared: rdata=%h done=%b, required 00 000", req_rdata, req_done);
        end
    endtask

    // rr_ptr is 2 after the read on port 2, so the three-way order is 0,1,2
    // and the continuous 1/2 phase alternates.
    task automatic test_arbitration();
        int ord [7] = '{0, 1, 2, 1, 2, 1, 2};
        int td;
        logic [NR-1:0] d;
        eng_auto = 1'b1; eng_lat = 3;
        for (int i = 0; i < NR; i++) begin
            ra[i] = AW'(10'h100 + i); rw[i] = DW'(8'h10 + i); req_rnw[i] = 1'b0;
        end
        push(0, 1'b0, ra[0], rw[0], 1'b0, 8'h00);
        push(1, 1'b0, ra[1], rw[1], 1'b0, 8'h00);
        push(2, 1'b0, ra[2], rw[2], 1'b0, 8'h00);
        req_valid = 3'b111;
        for (int k = 0; k < 7; k++) begin
            wait_done(50, d, td);
            n_tests++;
            if (d !== (NR'(1) << ord[k])) begin
                n_fail++;
                $display("FAIL arb_order[%0d]: done=%b, required %b", k, d, NR'(1) << ord[k]);
            end
            req_valid = req_valid & ~d;
            if (k == 2) begin
                push(1, 1'b0, ra[1], rw[1], 1'b0, 8'h00);
                push(2, 1'b0, ra[2], rw[2], 1'b0, 8'h00);
                req_valid = 3'b110;
            end else if (k == 3 || k == 4) begin
                @(negedge clk);
                push(ord[k], 1'b0, ra[ord[k]], rw[ord[k]], 1'b0, 8'h00);
                req_valid[ord[k]] = 1'b1;
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int ts, td;
        logic [NR-1:0] d;
        eng_auto = 1'b0;
        ra[1] = 10'h123; req_rnw[1] = 1'b1;
        push(1, 1'b1, 10'h123, rw[1], 1'b1, 8'h00);
        req_valid[1] = 1'b1;
        wait_start(5, ts);
        wait_done(TO + 20, d, td);
        req_valid[1] = 1'b0;
        n_tests++;
        if (d !== 3'b010 || req_err !== 3'b010 || req_rdata !== 8'h00 || td - ts !== TO) begin
            n_fail++;
            $display("FAIL timeout: done=%b err=%b rdata=%h cycles=%0d, required 010 010 00 %0d", d, req_err, req_rdata, td - ts, TO);
        end
        // End pulse in the very cycle the counter expires: end must win.
        @(negedge clk);
        eng_auto = 1'b1; eng_lat = TO - 1; eng_rval = 8'h7E;
        push(1, 1'b1, 10'h123, rw[1], 1'b0, 8'h7E);
        req_valid[1] = 1'b1;
        wait_start(5, ts);
        wait_done(TO + 20, d, td);
        req_valid[1] = 1'b0;
        n_tests++;
        if (d !== 3'b010 || req_err !== 3'b000 || req_rdata !== 8'h7E || td - ts !== TO) begin
            n_fail++;
            $display("FAIL end_beats_timeout: done=%b err=%b rdata=%h cycles=%0d, required 010 000 7e %0d", d, req_err, req_rdata, td - ts, TO);
        end
        @(negedge clk);
    endtask

    task automatic test_stray_ends();
        int ts, bad;
        eng_auto = 1'b0;
        s_wr = 1'b1;
        @(negedge clk);
        s_wr = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_done != '0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stray_idle: bad_cycles=%0d, required 0", bad);
        end
        ra[2] = 10'h055; rw[2] = 8'h11; req_rnw[2] = 1'b0;
        push(2, 1'b0, 10'h055, 8'h11, 1'b0, 8'h00);
        req_valid[2] = 1'b1;
        wait_start(5, ts);
        @(negedge clk);
        s_rd = 1'b1;
        @(negedge clk);
        s_rd = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_done != '0 || busy !== 1'b1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stray_wrong_type: bad_cycles=%0d, required 0", bad);
        end
        s_wr = 1'b1;
        @(negedge clk);
        s_wr = 1'b0;
        n_tests++;
        if (req_done !== 3'b100 || req_err !== 3'b000) begin
            n_fail++;
            $display("FAIL stray_then_real_end: done=%b err=%b, required 100 000", req_done, req_err);
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ts, td;
        logic [NR-1:0] d;
        eng_auto = 1'b0;
        ra[1] = 10'h2AA; rw[1] = 8'h33; req_rnw[1] = 1'b0;
        push(1, 1'b0, 10'h2AA, 8'h33, 1'b0, 8'h00);
        req_valid[1] = 1'b1;
        wait_start(5, ts);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, eng_wr_req, eng_rd_req, req_done, req_err, req_rdata, eng_addr, eng_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b addr=%h wdata=%h done=%b, required all 0", busy, eng_addr, eng_wdata, req_done);
        end
        repeat (2) @(negedge clk);
        eng_auto = 1'b1; eng_lat = 4;
        rst_n = 1'b1;
        wait_start(5, ts);
        n_tests++;
        if (ts < 0 || eng_addr !== 10'h2AA) begin
            n_fail++;
            $display("FAIL reset_restart: start_cycle=%0d addr=%h, required a start with addr 2aa", ts, eng_addr);
        end
        wait_done(50, d, td);
        req_valid[1] = 1'b0;
        n_tests++;
        if (d !== 3'b010 || td - ts !== 5) begin
            n_fail++;
            $display("FAIL reset_restart_done: done=%b cycles=%0d, required 010 5", d, td - ts);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rw[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_timeout();
        test_stray_ends();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
